control_fpgaram: RTL and testbench

CONTROL_FPGARAM -- requirements
Module: control_fpgaram

---
 rtl/control_fpgaram.sv | 84 ++++++++
 tb/tb_control_fpgaram.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fpgaram.sv
// control_fpgaram: arbitrates an external SRAM between a microcontroller and a FIFO-fed boot loader.
// Ports:
//   control_mem_clk_i / control_mem_rst_i : clock, asynchronous active-low reset
//   micro_sram_*_i, micro_control        : micro-side SRAM bus and ownership request (1 = micro)
//   write_enable_i, fifo_datain_i        : boot FIFO status {permit, not_empty} and pop data
//   read_fifo_o                          : one-cycle FIFO pop strobe
//   sram_*_o                             : SRAM bus (strobes and byte enables active-low)
//   sram_wait_o                          : high while a boot word is in flight
module control_fpgaram #(
    parameter int WR_CYCLES = 3
) (
    input  logic        control_mem_clk_i,
    input  logic        control_mem_rst_i,
    input  logic [21:0] micro_sram_address_i,
    input  logic [31:0] micro_sram_datain_i,
    input  logic        micro_sram_cs_i,
    input  logic        micro_sram_we_i,
    input  logic        micro_sram_oe_i,
    input  logic [1:0]  micro_sram_lb_ub_i,
    input  logic        micro_sram_adv_i,
    input  logic        micro_control,
    input  logic [1:0]  write_enable_i,
    input  logic [31:0] fifo_datain_i,
    output logic        read_fifo_o,
    output logic [21:0] sram_address_o,
    output logic [31:0] sram_datain_o,
    output logic        sram_cs_o,
    output logic        sram_we_o,
    output logic        sram_oe_o,
    output logic        sram_adv_o,
    output logic [1:0]  sram_lb_ub_o,
    output logic        sram_wait_o
);
    localparam int CW = $clog2(WR_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, SETUP, WRITE, HOLD, DONE} state_t;
    state_t state, next;
    logic [CW-1:0] cnt;
    logic owner;
    logic [21:0] addr;
    logic [31:0] data;
    logic boot_cs, boot_we, boot_adv;
    // Ownership is only sampled between words, so a boot word can never be torn by the micro.
    always_ff @(posedge control_mem_clk_i or negedge control_mem_rst_i) begin
        if (!control_mem_rst_i) begin
            state <= IDLE;
            owner <= 1'b0;
            addr  <= '0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            state <= next;
            if (state == IDLE) owner <= micro_control;
            if (state == IDLE && !write_enable_i[1]) addr <= '0;
            else if (state == DONE) addr <= addr + 22'd1;
            if (state == LATCH) data <= fifo_datain_i;
            cnt <= (state == WRITE) ? cnt + 1'b1 : '0;
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (!owner && write_enable_i == 2'b11) ? FETCH : IDLE;
            FETCH:   next = LATCH;
            LATCH:   next = SETUP;
            SETUP:   next = WRITE;
            WRITE:   next = (cnt == CW'(WR_CYCLES - 1)) ? HOLD : WRITE;
            HOLD:    next = DONE;
            default: next = IDLE;
        endcase
        boot_cs  = !(state == SETUP || state == WRITE || state == HOLD);
        boot_we  = state != WRITE;
        boot_adv = state != SETUP;
    end
    assign read_fifo_o    = !owner && state == FETCH;
    assign sram_wait_o    = state != IDLE;
    assign sram_address_o = owner ? micro_sram_address_i : addr;
    assign sram_datain_o  = owner ? micro_sram_datain_i : data;
    assign sram_cs_o      = owner ? micro_sram_cs_i : boot_cs;
    assign sram_we_o      = owner ? micro_sram_we_i : boot_we;
    assign sram_oe_o      = owner ? micro_sram_oe_i : 1'b1;
    assign sram_adv_o     = owner ? micro_sram_adv_i : boot_adv;
    // Byte lanes stay enabled for the whole chip-select window of a boot write.
    assign sram_lb_ub_o   = owner ? micro_sram_lb_ub_i : {2{boot_cs}};
endmodule

// File: tb/tb_control_fpgaram.sv
// tb_control_fpgaram: directed bench for control_fpgaram covering reset, passthrough, boot writes, burst, wrap, ownership switch and mid-write reset.
module tb_control_fpgaram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] micro_sram_address_i = '0;
    logic [31:0] micro_sram_datain_i = '0;
    logic        micro_sram_cs_i = 1'b1;
    logic        micro_sram_we_i = 1'b1;
    logic        micro_sram_oe_i = 1'b1;
    logic [1:0]  micro_sram_lb_ub_i = 2'b11;
    logic        micro_sram_adv_i = 1'b1;
    logic        micro_control = 1'b0;
    logic [1:0]  write_enable_i = 2'b00;
    logic [31:0] fifo_datain_i = '0;
    logic        read_fifo_o;
    logic [21:0] sram_address_o;
    logic [31:0] sram_datain_o;
    logic        sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o, sram_wait_o;
    logic [1:0]  sram_lb_ub_o;
    int total = 0;
    int bad = 0;

    control_fpgaram dut (
        .control_mem_clk_i(clk),
        .control_mem_rst_i(rst_n),
        .micro_sram_address_i(micro_sram_address_i),
        .micro_sram_datain_i(micro_sram_datain_i),
        .micro_sram_cs_i(micro_sram_cs_i),
        .micro_sram_we_i(micro_sram_we_i),
        .micro_sram_oe_i(micro_sram_oe_i),
        .micro_sram_lb_ub_i(micro_sram_lb_ub_i),
        .micro_sram_adv_i(micro_sram_adv_i),
        .micro_control(micro_control),
        .write_enable_i(write_enable_i),
        .fifo_datain_i(fifo_datain_i),
        .read_fifo_o(read_fifo_o),
        .sram_address_o(sram_address_o),
        .sram_datain_o(sram_datain_o),
        .sram_cs_o(sram_cs_o),
        .sram_we_o(sram_we_o),
        .sram_oe_o(sram_oe_o),
        .sram_adv_o(sram_adv_o),
        .sram_lb_ub_o(sram_lb_ub_o),
        .sram_wait_o(sram_wait_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one boot word from IDLE and checks pop count, write window, address/data, busy length and counter advance.
    task automatic do_word(input string tag, input logic [21:0] ea, input logic [31:0] ed);
        int pops = 0;
        int wlo = 0;
        int wt = 0;
        int wrong = 0;
        logic [21:0] nxt;
        nxt = ea + 22'd1;
        fifo_datain_i = 32'h0BAD_0BAD;
        write_enable_i = 2'b11;
        tick();
        write_enable_i = 2'b10;
        fifo_datain_i = ed;
        for (int i = 0; i < 12; i++) begin
            if (read_fifo_o) pops++;
            if (sram_wait_o) wt++;
            if (!sram_we_o) begin
                wlo++;
                if (sram_address_o !== ea || sram_datain_o !== ed || sram_cs_o !== 1'b0) wrong++;
            end
            tick();
        end
        chk({tag, "_pops"}, pops, 1);
        chk({tag, "_we_low_cycles"}, wlo, 3);
        chk({tag, "_write_bus"}, wrong, 0);
        chk({tag, "_wait_cycles"}, wt, 8);
        chk({tag, "_counter_after"}, {10'd0, sram_address_o}, {10'd0, nxt});
    endtask

    initial begin
        int pops;
        int nw;
        int pop_cyc[8];
        logic [21:0] wa[8];
        logic prev_we;
        // Reset with deliberately busy inputs.
        micro_control = 1'b1;
        micro_sram_address_i = 22'h3ABCDE;
        micro_sram_datain_i = 32'hFFFF_0000;
        micro_sram_cs_i = 1'b0;
        micro_sram_we_i = 1'b0;
        micro_sram_oe_i = 1'b0;
        micro_sram_lb_ub_i = 2'b00;
        micro_sram_adv_i = 1'b0;
        write_enable_i = 2'b11;
        fifo_datain_i = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_fifo", read_fifo_o, 0);
        chk("rst_wait", sram_wait_o, 0);
        chk("rst_strobes", {sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o}, 4'hF);
        chk("rst_lb_ub", sram_lb_ub_o, 2'b11);
        chk("rst_addr", sram_address_o, 0);
        chk("rst_data", sram_datain_o, 0);
        // Passthrough.
        write_enable_i = 2'b00;
        micro_sram_address_i = 22'h12345;
        micro_sram_datain_i = 32'hDEADBEEF;
        micro_sram_cs_i = 1'b0;
        micro_sram_we_i = 1'b0;
        micro_sram_oe_i = 1'b1;
        micro_sram_lb_ub_i = 2'b10;
        micro_sram_adv_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("pt_addr", sram_address_o, 32'h12345);
        chk("pt_data", sram_datain_o, 32'hDEADBEEF);
        chk("pt_strobes", {sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o}, 4'b0010);
        chk("pt_lb_ub", sram_lb_ub_o, 2'b10);
        chk("pt_read_fifo", read_fifo_o, 0);
        micro_sram_address_i = 22'h00777;
        #1;
        chk("pt_comb_addr", sram_address_o, 32'h00777);
        // Back to boot ownership, idle values.
        micro_control = 1'b0;
        tick();
        chk("boot_idle_strobes", {sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o}, 4'hF);
        chk("boot_idle_addr", sram_address_o, 0);
        chk("boot_idle_wait", sram_wait_o, 0);
        // Single word, then idle holds the data register.
        do_word("single", 22'h0, 32'hA5A5A5A5);
        chk("single_idle_data", sram_datain_o, 32'hA5A5A5A5);
        chk("single_idle_lb_ub", sram_lb_ub_o, 2'b11);
        // Clear, then burst of four words.
        write_enable_i = 2'b00;
        tick();
        chk("clear_before_burst", sram_address_o, 0);
        write_enable_i = 2'b11;
        tick();
        pops = 0;
        nw = 0;
        prev_we = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (read_fifo_o && pops < 8) begin
                pop_cyc[pops] = c;
                pops++;
                fifo_datain_i = 32'h1000_0000 + pops;
                if (pops == 4) write_enable_i = 2'b10;
            end
            if (!sram_we_o && prev_we && nw < 8) begin
                wa[nw] = sram_address_o;
                nw++;
            end
            prev_we = sram_we_o;
            tick();
        end
        chk("burst_pops", pops, 4);
        chk("burst_writes", nw, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("burst_addr%0d", k), {10'd0, wa[k]}, k);
        chk("burst_spacing", pop_cyc[3] - pop_cyc[0], 27);
        chk("burst_counter", sram_address_o, 4);
        write_enable_i = 2'b00;
        tick();
        chk("burst_clear", sram_address_o, 0);
        // Wrap at the top of the address space.
        write_enable_i = 2'b10;
        @(negedge clk);
        force dut.addr = 22'h3FFFFF;
        #1;
        release dut.addr;
        #1;
        chk("wrap_preload", sram_address_o, 32'h3FFFFF);
        tick();
        do_word("wrap", 22'h3FFFFF, 32'hC3C3_3C3C);
        // Ownership request raised in the middle of a write.
        write_enable_i = 2'b11;
        tick();
        write_enable_i = 2'b10;
        fifo_datain_i = 32'h5555_AAAA;
        repeat (3) tick();
        micro_control = 1'b1;
        micro_sram_address_i = 22'h2AAAA;
        micro_sram_datain_i = 32'h1234_5678;
        micro_sram_cs_i = 1'b0;
        micro_sram_we_i = 1'b0;
        micro_sram_oe_i = 1'b0;
        micro_sram_lb_ub_i = 2'b01;
        micro_sram_adv_i = 1'b0;
        #1;
        chk("own_write_boot", {sram_we_o, sram_oe_o, sram_adv_o}, 3'b011);
        chk("own_write_addr", sram_address_o, 0);
        repeat (3) tick();
        chk("own_hold", {sram_cs_o, sram_we_o, sram_oe_o}, 3'b011);
        tick();
        chk("own_done", {sram_cs_o, sram_wait_o}, 2'b11);
        tick();
        chk("own_first_idle", {sram_wait_o, read_fifo_o, sram_oe_o}, 3'b001);
        tick();
        chk("own_micro_addr", sram_address_o, 32'h2AAAA);
        chk("own_micro_data", sram_datain_o, 32'h1234_5678);
        chk("own_micro_strobes", {sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o, sram_lb_ub_o}, 6'b000001);
        // Reset in the middle of a write.
        micro_control = 1'b0;
        tick();
        write_enable_i = 2'b11;
        tick();
        write_enable_i = 2'b10;
        repeat (3) tick();
        chk("mid_is_writing", sram_we_o, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o, sram_wait_o, read_fifo_o}, 6'b111100);
        chk("mid_rst_addr", sram_address_o, 0);
        chk("mid_rst_data", sram_datain_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_idle", {sram_wait_o, sram_we_o}, 2'b01);
        chk("post_rst_addr", sram_address_o, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
